// File: rtl/sram_bus_pkg.sv
// Shared definitions for the external SRAM bus: state encoding, default widths
// and the implemented SRAM size (matches the FIFO controller depth).
package sram_bus_pkg;

  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 11;
  localparam int SRAM_DEPTH  = 8;
  localparam int SRAM_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_TURN  = 2'b11
  } sram_state_e;

endpackage

// File: rtl/sram_word_array.sv
// Word storage with a synchronous write port and a synchronous read register.
// With SRAM_PARITY_EN defined, an even-parity column is stored and checked on read.
module sram_word_array
  import sram_bus_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = SRAM_DEPTH,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              in_range,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
`ifdef SRAM_PARITY_EN
  input  logic              inj_par,
  output logic              par_fail,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the storage array has no reset; contents are undefined until written,
  // which lets it map onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= in_range ? mem_q[idx] : '0;
    end
  end

  assign rdata = rdata_q;

`ifdef SRAM_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) par_q[idx] <= (^wdata) ^ inj_par;
  end

  assign par_fail = re && in_range && ((^mem_q[idx]) != par_q[idx]);
`endif

endmodule

// File: rtl/sram_responder.sv
// SRAM responder on the FIFO controller's external bus: FSM, tri-state driver,
// sticky protocol flags and transaction counters. Optional parity: SRAM_PARITY_EN.
module sram_responder
  import sram_bus_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DEPTH  = SRAM_DEPTH,
  parameter int CNT_W  = SRAM_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rd,
  input  logic              wr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic [1:0]        state,
  output logic              coll_err,
  output logic              addr_err,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  input  logic              inj_par,
  output logic              par_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sram_state_e       state_q, state_d;
  logic              coll_err_q, addr_err_q;
  logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q;
  logic [DATA_W-1:0] rdata;

  logic rd_req, wr_req, coll, in_range, rd_done, wr_done;

  assign rd_req   = !rd && wr;
  assign wr_req   = !wr && rd;
  assign coll     = !rd && !wr;
  assign in_range = address < ADDR_W'(DEPTH);

  // NOTE: next state is defaulted before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_TURN: begin
        if (rd_req)      state_d = ST_READ;
        else if (wr_req) state_d = ST_WRITE;
        else             state_d = ST_IDLE;
      end
      ST_READ:  if (coll || rd) state_d = ST_TURN;
      ST_WRITE: if (coll || wr) state_d = ST_TURN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Collision-forced exits leave the counters untouched.
  assign rd_done = (state_q == ST_READ)  && rd && !coll;
  assign wr_done = (state_q == ST_WRITE) && wr && !coll;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      coll_err_q <= 1'b0;
      addr_err_q <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (coll)                    coll_err_q <= 1'b1;
      if ((!rd || !wr) && !in_range) addr_err_q <= 1'b1;
      if (rd_done) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      if (wr_done) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
    end
  end

`ifdef SRAM_PARITY_EN
  logic par_fail, par_err_q;

  sram_word_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_req && in_range),
    .re       (rd_req),
    .in_range (in_range),
    .idx      (address[IDX_W-1:0]),
    .wdata    (sram_data),
    .inj_par  (inj_par),
    .par_fail (par_fail),
    .rdata    (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          par_err_q <= 1'b0;
    else if (par_fail) par_err_q <= 1'b1;
  end

  assign par_err = par_err_q;
`else
  logic unused_inj_par;

  sram_word_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_req && in_range),
    .re       (rd_req),
    .in_range (in_range),
    .idx      (address[IDX_W-1:0]),
    .wdata    (sram_data),
    .rdata    (rdata)
  );

  assign unused_inj_par = inj_par;
  assign par_err        = 1'b0;
`endif

  // Reset forces state_q to IDLE asynchronously, so the bus releases at once.
  assign sram_data = (state_q == ST_READ) ? rdata : {DATA_W{1'bz}};

  assign state    = state_q;
  assign coll_err = coll_err_q;
  assign addr_err = addr_err_q;
  assign rd_cnt   = rd_cnt_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Behavioural-plus-synthesizable SRAM device model. It is the responder end of the FIFO controller's external SRAM bus.
- It accepts the controller's active-low rd/wr strobes, the address and the bidirectional sram_data bus. It stores words and drives read data back.
- It flags protocol violations and counts completed transactions, for bring-up and verification.

Parameters:
DATA_W, 16, sram_data width
ADDR_W, 11, address width
DEPTH, 8, number of implemented words; addresses >= DEPTH are out of range
CNT_W, 16, width of transaction counters

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
address  input  ADDR_W  word address from initiator
rd  input  1  active-low read strobe
wr  input  1  active-low write strobe
sram_data  inout  DATA_W  shared data bus; driven by this block only in READ state
state  output  2  FSM state: IDLE=00, READ=01, WRITE=10, TURN=11
coll_err  output  1  sticky: rd and wr sampled low on the same edge
addr_err  output  1  sticky: access strobe sampled low with address >= DEPTH
rd_cnt  output  CNT_W  completed read transactions, wraps
wr_cnt  output  CNT_W  completed write transactions, wraps
inj_par  input  1  parity-error injection (used only with SRAM_PARITY_EN)
par_err  output  1  sticky parity error (tied 0 without SRAM_PARITY_EN)

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, bus released (Z), read register=0, coll_err=0, addr_err=0, par_err=0, rd_cnt=0, wr_cnt=0. Memory contents are not reset (X until written).
- FSM, evaluated each rising edge:
  - From IDLE or TURN: rd=0,wr=1 -> READ; wr=0,rd=1 -> WRITE; both low -> IDLE and set coll_err; both high -> IDLE.
  - READ: rd=1 -> TURN; rd=0 -> READ.
  - WRITE: wr=1 -> TURN; wr=0 -> WRITE.
  - In READ or WRITE, both strobes low sets coll_err and forces TURN.
  - TURN lasts exactly one cycle with the bus undriven, then behaves as IDLE.
- Write: every edge with wr=0, rd=1 and address<DEPTH loads mem[address] <= sram_data. Repeated edges re-write the same word, which is harmless. Out-of-range writes are discarded and set addr_err.
- Read:
  - Every edge with rd=0, wr=1 loads rdata_q <= mem[address]; out-of-range reads load 0 and set addr_err.
  - sram_data = rdata_q while state==READ, else Z.
  - Latency: data appears one cycle after the first edge that samples rd low. An address change while rd is held low is reflected one cycle later.
- Counters: rd_cnt increments on the READ->TURN transition, wr_cnt on WRITE->TURN. Both wrap modulo 2^CNT_W. A collision-forced exit does not count.
- Simultaneous or degenerate cases:
  - Both strobes low: no write, no drive.
  - A strobe low during TURN is accepted on that edge; the state moves directly to READ/WRITE.
  - Reset mid-access releases the bus immediately (asynchronous), without waiting for the clock.
- Sticky flags clear only on reset.

Optional Feature:
SRAM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit computed from sram_data at write time. If inj_par=1 on the write edge, the stored parity bit is inverted.
  - On each read load, recomputed parity is compared with the stored bit. A mismatch on an in-range read sets par_err (sticky).
- Undefined: no parity storage, inj_par ignored, par_err constant 0.

Decomposition:
- Shared package sram_bus_pkg:
  - State encoding constants (IDLE/READ/WRITE/TURN).
  - DATA_W/ADDR_W defaults.
  - SRAM size constant, shared with the FIFO controller's depth of 8.
- One natural sub-module, sram_word_array: storage array with synchronous write port and synchronous read register (plus parity column when enabled). The FSM, bus driver, flags and counters stay in the top level.

Test Plan:
- Reset released, strobes high -> state=00, sram_data=Z, all flags 0, rd_cnt=wr_cnt=0.
- Write 16'hA5A5 to addr 3 (wr low 2 cycles) then read addr 3 (rd low 3 cycles) -> sram_data=16'hA5A5 from the cycle after rd is first sampled low; wr_cnt=1, rd_cnt=1; one TURN cycle with Z after each access.
- Write addr 0..7 with 16'h1000+i, then read 7..0 -> each returns 16'h1000+i; counters=8/8; addr_err=0.
- Write to addr 9 then read addr 9 -> addr_err=1; mem[0..7] unchanged; read returns 16'h0000.
- rd and wr both low for one edge in IDLE -> coll_err=1, no memory change, bus stays Z; rst pulsed low mid-read -> bus Z immediately, counters 0.
- SRAM_PARITY_EN: write 16'h0001 to addr 2 with inj_par=1, then read addr 2 -> par_err=1; clean write/read of addr 4 -> par_err remains as before (no new set).
